// File: rtl/keypad_pkg.sv
// Shared keypad geometry, scanner FSM state encoding and key-image helpers.
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;
  localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    COMMIT = 2'd3
  } state_t;

  function automatic int key_idx(input int row, input int col);
    return row * NUM_COLS + col;
  endfunction

  function automatic logic rows_clash(input logic [NUM_COLS-1:0] a,
                                      input logic [NUM_COLS-1:0] b);
    return $countones(a & b) >= 2;
  endfunction

  // Two rows sharing two pressed columns form a rectangle whose fourth corner
  // may be phantom, so the whole image is untrustworthy.
  function automatic logic frame_is_ghost(input logic [NUM_KEYS-1:0] img);
    return rows_clash(img[3:0],  img[7:4])   |
           rows_clash(img[3:0],  img[11:8])  |
           rows_clash(img[3:0],  img[15:12]) |
           rows_clash(img[7:4],  img[11:8])  |
           rows_clash(img[7:4],  img[15:12]) |
           rows_clash(img[11:8], img[15:12]);
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad scanner signal bundle: host/keypad side (master) and scanner side (slave).
interface keypad_scanner_if;
  import keypad_pkg::*;

  logic                scan_en;
  logic [NUM_COLS-1:0] col_n;
  logic [NUM_ROWS-1:0] row_n;
  logic [NUM_KEYS-1:0] key_n;
  logic                scan_done;
  logic                ghost;

  modport slave (
    input  scan_en, col_n,
    output row_n, key_n, scan_done, ghost
  );

  modport master (
    output scan_en, col_n,
    input  row_n, key_n, scan_done, ghost
  );

endinterface

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous level inputs.
module sync2 #(
  parameter int              WIDTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_p0;
  logic [WIDTH-1:0] sync_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_p0 <= RST_VAL;
      sync_p1 <= RST_VAL;
    end else begin
      meta_p0 <= d;
      sync_p1 <= meta_p0;
    end
  end

  assign q = sync_p1;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: drives one row at a time, samples columns after a
// settle time, and publishes a whole-frame key image. Optional ghost-frame
// rejection is enabled by defining GHOST_MASK_EN.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = 1000
) (
  input  logic              clk,
  input  logic              rst,
  keypad_scanner_if.slave   kif
);

  localparam logic [15:0] LAST_CNT = 16'(SETTLE_CYC - 1);
  localparam logic [1:0]  LAST_ROW = 2'(NUM_ROWS - 1);

  logic [NUM_COLS-1:0] col_s;

  sync2 #(.WIDTH(NUM_COLS), .RST_VAL('1)) u_col_sync (
    .clk (clk),
    .rst (rst),
    .d   (kif.col_n),
    .q   (col_s)
  );

  state_t              state_q, state_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [1:0]          row_q, row_d;
  logic [NUM_KEYS-1:0] shadow_q, shadow_d;
  logic [NUM_KEYS-1:0] key_q, key_d;
  logic [NUM_ROWS-1:0] row_n_c;
  logic                scan_done_c;
  logic                ghost_c;
  logic [3:0]          base;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      row_q    <= '0;
      shadow_q <= '0;
      key_q    <= '1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      row_q    <= row_d;
      shadow_q <= shadow_d;
      key_q    <= key_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    row_d       = row_q;
    shadow_d    = shadow_q;
    key_d       = key_q;
    row_n_c     = '1;
    scan_done_c = 1'b0;
    ghost_c     = 1'b0;
    base        = 4'(key_idx(int'(row_q), 0));

    case (state_q)
      IDLE: begin
        cnt_d    = '0;
        row_d    = '0;
        shadow_d = '0;
        if (kif.scan_en) state_d = DRIVE;
      end

      DRIVE: begin
        row_n_c = ~(4'b0001 << row_q);
        if (!kif.scan_en) begin
          state_d = IDLE;
        end else if (cnt_q == LAST_CNT) begin
          state_d = SAMPLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      SAMPLE: begin
        row_n_c = ~(4'b0001 << row_q);
        if (!kif.scan_en) begin
          state_d = IDLE;
        end else begin
          shadow_d[base +: NUM_COLS] = ~col_s;
          if (row_q == LAST_ROW) begin
            state_d = COMMIT;
          end else begin
            row_d   = row_q + 2'd1;
            cnt_d   = '0;
            state_d = DRIVE;
          end
        end
      end

      COMMIT: begin
        row_d = '0;
        cnt_d = '0;
`ifdef GHOST_MASK_EN
        if (frame_is_ghost(shadow_q)) begin
          ghost_c = 1'b1;
        end else begin
          key_d       = ~shadow_q;
          scan_done_c = 1'b1;
        end
`else
        key_d       = ~shadow_q;
        scan_done_c = 1'b1;
`endif
        state_d = kif.scan_en ? DRIVE : IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign kif.row_n     = row_n_c;
  assign kif.key_n     = key_q;
  assign kif.scan_done = scan_done_c;
  assign kif.ghost     = ghost_c;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed scoreboard bench for keypad_scanner with SETTLE_CYC = 8; honours GHOST_MASK_EN.
module tb_keypad_scanner;
  import keypad_pkg::*;

  typedef struct packed {
    logic [15:0] key;
    logic        ghost;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] keys;
  logic [3:0]  col_model;
  exp_t        sb[$];
  int          vectors = 0;
  int          miscompares = 0;

  keypad_scanner_if kif ();

  keypad_scanner #(.SETTLE_CYC(8)) dut (
    .clk (clk),
    .rst (rst),
    .kif (kif)
  );

  always #5 clk = ~clk;

  // Ideal matrix: a pressed key pulls its column low while its row is driven.
  always_comb begin
    col_model = 4'hF;
    if (!kif.row_n[0]) col_model = col_model & ~keys[3:0];
    if (!kif.row_n[1]) col_model = col_model & ~keys[7:4];
    if (!kif.row_n[2]) col_model = col_model & ~keys[11:8];
    if (!kif.row_n[3]) col_model = col_model & ~keys[15:12];
  end
  assign kif.col_n = col_model;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // Called on the negedge of the first cycle of a frame; waits for its end.
  task automatic check_frame(input string tag);
    int   cyc;
    exp_t e;
    cyc = 0;
    while (kif.scan_done !== 1'b1 && kif.ghost !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_period"}, cyc, 36);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'(sb.size()), 1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_done"},  32'(kif.scan_done), 32'(!e.ghost));
      chk({tag, "_ghost"}, 32'(kif.ghost),     32'(e.ghost));
      @(negedge clk);
      chk({tag, "_key"}, 32'(kif.key_n), 32'(e.key));
    end
  endtask

  initial begin
    logic [3:0] row_pat [4];
    exp_t       e;
    int         pulses;
    row_pat[0] = 4'hE;
    row_pat[1] = 4'hD;
    row_pat[2] = 4'hB;
    row_pat[3] = 4'h7;

    rst         = 1'b1;
    kif.scan_en = 1'b1;
    keys        = 16'h0000;
    repeat (3) @(negedge clk);
    kif.scan_en = 1'b0;
    rst         = 1'b0;
    @(negedge clk);
    chk("rst_row_n",     32'(kif.row_n),     32'h0000000F);
    chk("rst_key_n",     32'(kif.key_n),     32'h0000FFFF);
    chk("rst_scan_done", 32'(kif.scan_done), 0);
    chk("rst_ghost",     32'(kif.ghost),     0);

    // First frame: row walk and 37-cycle latency to scan_done.
    sb.push_back('{key: 16'hFFFF, ghost: 1'b0});
    kif.scan_en = 1'b1;
    for (int c = 1; c <= 37; c++) begin
      @(negedge clk);
      chk($sformatf("walk_row_c%0d", c), 32'(kif.row_n),
          (c <= 36) ? 32'(row_pat[(c - 1) / 9]) : 32'h0000000F);
      chk($sformatf("walk_done_c%0d", c), 32'(kif.scan_done), (c == 37) ? 1 : 0);
    end
    e = sb.pop_front();
    @(negedge clk);
    chk("walk_key", 32'(kif.key_n), 32'(e.key));

    keys = 16'h0200;
    sb.push_back('{key: 16'hFDFF, ghost: 1'b0});
    check_frame("r2c1");

    keys = 16'h0033;
`ifdef GHOST_MASK_EN
    sb.push_back('{key: 16'hFDFF, ghost: 1'b1});
`else
    sb.push_back('{key: 16'hFFCC, ghost: 1'b0});
`endif
    check_frame("square");

    keys = 16'h0000;
    sb.push_back('{key: 16'hFFFF, ghost: 1'b0});
    check_frame("release");

    // Abort during row 2 DRIVE.
    keys = 16'h0001;
    repeat (20) @(negedge clk);
    chk("abort_pre_row", 32'(kif.row_n), 32'h0000000B);
    kif.scan_en = 1'b0;
    @(negedge clk);
    chk("abort_row_n", 32'(kif.row_n), 32'h0000000F);
    chk("abort_state", 32'(dut.state_q), 32'(IDLE));
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      if (kif.scan_done === 1'b1) pulses++;
      @(negedge clk);
    end
    chk("abort_no_done", 32'(pulses), 0);
    chk("abort_key_held", 32'(kif.key_n), 32'h0000FFFF);
    kif.scan_en = 1'b1;
    @(negedge clk);
    chk("restart_row0", 32'(kif.row_n), 32'h0000000E);
    sb.push_back('{key: 16'hFFFE, ghost: 1'b0});
    check_frame("restart");

    // Reset during SAMPLE of row 3.
    keys = 16'h8000;
    repeat (35) @(negedge clk);
    chk("pre_rst_row", 32'(kif.row_n), 32'h00000007);
    chk("pre_rst_state", 32'(dut.state_q), 32'(SAMPLE));
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_done",  32'(kif.scan_done), 0);
    chk("midrst_key",   32'(kif.key_n),     32'h0000FFFF);
    chk("midrst_row",   32'(kif.row_n),     32'h0000000F);
    chk("midrst_state", 32'(dut.state_q),   32'(IDLE));
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_done", 32'(kif.scan_done), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter SETTLE_CYC, default 1000, clk cycles each row is driven before its columns are sampled (legal range 4..65535).
REQ-002 clk  input  1  single clock domain for all logic.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 scan_en  input  1  high = scanning runs; low = idle.
REQ-005 col_n  input  4  keypad column lines, externally pulled up, low = key closed on the driven row; asynchronous to clk.
REQ-006 row_n  output  4  keypad row drives, active-low, at most one bit low at any time.
REQ-007 key_n  output  16  debounce-ready key image, active-low, bit index = row*4 + col.
REQ-008 scan_done  output  1  one-cycle pulse per completed, accepted frame.
REQ-009 ghost  output  1  one-cycle pulse per rejected frame (GHOST_MASK_EN only; tied 0 otherwise).

Function
REQ-010 col_n SHALL pass through a 2-flop synchronizer before any use; the scanner uses only the synchronized value.
REQ-011 FSM states SHALL be IDLE, DRIVE, SAMPLE and COMMIT.
REQ-012 IDLE: row_n = 4'b1111, settle counter = 0, row index = 0; move to DRIVE when scan_en = 1.
REQ-013 DRIVE: row_n drives low only the bit for the current row index, and the settle counter increments each cycle; move to SAMPLE when the counter reaches SETTLE_CYC-1.
REQ-014 SAMPLE (1 cycle): the row is still driven; store the inverted synchronized col_n into shadow bits [row*4+3 : row*4].
- Row < 3: increment the row index, clear the counter, go to DRIVE.
- Row = 3: go to COMMIT.
REQ-015 COMMIT (1 cycle): row_n = 4'b1111; copy the shadow image, inverted, into key_n; pulse scan_done; clear the row index; go to DRIVE if scan_en = 1, otherwise IDLE.
REQ-016 Frame period SHALL be 4*(SETTLE_CYC+1)+1 cycles; key_n changes only in COMMIT, never with a partial frame.
REQ-017 scan_en low in any non-IDLE state SHALL abort the frame:
- next state IDLE, row_n = 4'b1111;
- shadow discarded, key_n held, no scan_done.
REQ-018 The settle counter SHALL be 16 bits and never wraps, because DRIVE exits at SETTLE_CYC-1.
REQ-019 Row index wraps from 3 to 0 only via COMMIT.

Reset
REQ-020 On rst = 1, registers SHALL take these values on the next clk edge, overriding scan_en:
- state = IDLE, row_n = 4'hF, key_n = 16'hFFFF;
- scan_done = 0, ghost = 0;
- shadow, counter and synchronizer flops = all-released.
REQ-021 Reset asserted mid-frame SHALL discard the frame with no scan_done pulse.

Configuration
REQ-022 With GHOST_MASK_EN defined, COMMIT SHALL reject a frame in which any two rows share two or more pressed columns.
- On reject: key_n held, scan_done = 0, ghost = 1 for one cycle.
REQ-023 Without GHOST_MASK_EN, every completed frame SHALL be committed and ghost SHALL be constant 0.

Structure
REQ-024 Shared package keypad_pkg SHALL hold:
- NUM_ROWS = 4 and NUM_COLS = 4;
- the FSM state enum;
- the index function row*NUM_COLS+col.
REQ-025 The 2-flop synchronizer SHALL be a separate sub-module, sync2, instantiated once with width 4.

Verification (SETTLE_CYC = 8)
REQ-026 Reset then scan_en = 1, no keys pressed:
- row_n cycles E, D, B, 7, each low for 9 cycles;
- scan_done first pulses 37 cycles after scan_en rises;
- key_n = 16'hFFFF.
REQ-027 Model holds key row 2/col 1 -> after the next full frame, key_n = 16'hFDFF with exactly one scan_done.
REQ-028 Model holds keys 0, 1, 4 and 5:
- with GHOST_MASK_EN: ghost pulses and key_n is unchanged;
- without it: key_n = 16'hFFCC.
REQ-029 scan_en dropped during row 2 DRIVE -> row_n = 4'hF on the next cycle, no scan_done, key_n held; re-enable restarts at row 0.
REQ-030 rst asserted during SAMPLE of row 3 -> no scan_done, key_n = 16'hFFFF next cycle, state IDLE.
